avst_latency_sink: RTL
======================

AVST_LATENCY_SINK -- requirements
Module: avst_latency_sink

Interface
REQ-001 The module SHALL have parameter DATABITS_PER_SYMBOL, default 8, meaning bits per symbol.
REQ-002 The module SHALL have parameter SYMBOLS_PER_BEAT, default 4, meaning symbols per beat; WIDTH = SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL.
REQ-003 The module SHALL have parameter READY_LATENCY, default 3, range 0..8, meaning cycles from ready to a permitted beat.
REQ-004 The module SHALL have parameter DEPTH, default 4, meaning buffer address bits; the buffer holds 2^DEPTH entries.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port data, input, WIDTH bits: Avalon-ST beat from the source.
REQ-008 The module SHALL have port valid, input, 1 bit: beat present (source to sink).
REQ-009 The module SHALL have port ready, output, 1 bit, registered: sink grants a beat READY_LATENCY cycles later.
REQ-010 The module SHALL have port out_data, output, WIDTH bits: head of buffer, show-ahead.
REQ-011 The module SHALL have port out_valid, output, 1 bit: buffer not empty.
REQ-012 The module SHALL have port out_ready, input, 1 bit: consumer pops when out_valid&&out_ready.
REQ-013 The module SHALL have port fill, output, DEPTH+1 bits: current entry count.
REQ-014 The module SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-015 The module SHALL record ready every cycle in a READY_LATENCY-deep history shift register.
REQ-016 A beat (valid=1 in cycle t) SHALL be legal iff ready was 1 in cycle t-READY_LATENCY; for READY_LATENCY=0 it SHALL be legal iff ready is 1 in cycle t.
REQ-017 Legal beats SHALL be written to the buffer in the same cycle, with zero bubbles and order preserved.
REQ-018 The module SHALL compute G(t) as the number of cycles in [t-READY_LATENCY+1, t] with ready=1, with G=0 for READY_LATENCY=0.
REQ-019 ready SHALL be 1 in cycle t+1 iff fill_next(t)+G(t) < 2^DEPTH, where fill_next includes this cycle's write and pop.
REQ-020 The module SHALL never accept a legal beat into a full buffer.
REQ-021 A simultaneous write and pop SHALL leave fill unchanged, including when fill=2^DEPTH.
REQ-022 When the buffer is empty, a write SHALL appear on out_valid/out_data in the next cycle, with no same-cycle bypass.
REQ-023 A pop when out_valid=0 SHALL be ignored.
REQ-024 Read and write pointers SHALL be DEPTH bits and wrap modulo 2^DEPTH.
REQ-025 The module SHALL sustain one beat per cycle continuously when out_ready=1 and DEPTH≥2 with 2^DEPTH > READY_LATENCY+1.
REQ-026 out_data SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While rst=1, the module SHALL hold ready=0, out_valid=0, fill=0, err=0, pointers=0 and history=0.
REQ-028 ready SHALL first assert in the first cycle after rst deasserts.
REQ-029 Beats arriving during rst, or within READY_LATENCY cycles after it, SHALL be ignored and SHALL not set err.
REQ-030 Reset asserted mid-stream SHALL discard all buffered and in-flight beats.

Configuration
REQ-031 With AVST_SINK_ERR_CHECK_EN defined, an illegal beat SHALL be dropped and err SHALL set the next cycle, remaining set until rst.
REQ-032 Without AVST_SINK_ERR_CHECK_EN, the legality check SHALL be omitted, err SHALL be tied 0, and every valid beat SHALL be written when the buffer is not full.

Verification
REQ-033 A bench SHALL cover: after reset, source sends 20 beats 0x00000001..0x00000014 honouring latency 3 with out_ready=1 -> all 20 out in order, err=0, ready never drops.
REQ-034 A bench SHALL cover: out_ready=0, continuous legal source -> ready deasserts, fill stops exactly at 16, no beat lost, and after out_ready=1 the 16 beats drain 1 per cycle.
REQ-035 A bench SHALL cover: valid=1 with data 0xDEADBEEF three cycles after ready=0, with the macro defined -> beat absent from output, err=1 next cycle and sticky.
REQ-036 A bench SHALL cover: fill=16 with a simultaneous legal write and pop -> fill stays 16, and output order is correct across pointer wrap.
REQ-037 A bench SHALL cover: rst pulsed for 1 cycle with fill=7 -> fill=0, out_valid=0 next cycle, ready=1 one cycle after rst falls.
REQ-038 A bench SHALL cover: READY_LATENCY=0 build, random valid and out_ready over 1000 cycles -> scoreboard matches, err=0.

Source files
------------

// File: rtl/avst_latency_sink.sv
// Avalon-ST sink honouring a fixed ready latency, feeding a show-ahead buffer.
// Define AVST_SINK_ERR_CHECK_EN to drop beats sent without a matching ready and flag err.
module avst_latency_sink #(
  parameter int unsigned DATABITS_PER_SYMBOL = 8,
  parameter int unsigned SYMBOLS_PER_BEAT    = 4,
  parameter int unsigned READY_LATENCY       = 3,
  parameter int unsigned DEPTH               = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL-1:0] data,
  input  logic                                            valid,
  output logic                                            ready,
  output logic [SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL-1:0] out_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DEPTH:0]                                  fill,
  output logic                                            err
);

  localparam int unsigned WIDTH   = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL;
  localparam int unsigned ENTRIES = 1 << DEPTH;
  localparam int unsigned HISTW   = (READY_LATENCY > 0) ? READY_LATENCY : 1;
  localparam int unsigned SUMW    = DEPTH + 5;

  localparam logic [DEPTH-1:0] PTR_ONE    = DEPTH'(1);
  localparam logic [DEPTH:0]   FILL_ONE   = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   FILL_FULL  = (DEPTH+1)'(ENTRIES);
  localparam logic [3:0]       GUARD_INIT = 4'(READY_LATENCY + 1);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [DEPTH-1:0] wptr_q, rptr_q;
  logic [DEPTH:0]   fill_q, fill_d;
  logic [HISTW-1:0] hist_q, hist_d;
  logic             ready_q, ready_d;
  logic [3:0]       guard_q;
  logic [3:0]       grants;
  logic [SUMW-1:0]  commit;
  logic             legal, full, pop, wr;

  always_comb begin
    // hist_q[k] holds ready from k+1 cycles ago
    legal = (READY_LATENCY == 0) ? ready_q : hist_q[HISTW-1];
    full  = (fill_q == FILL_FULL);
    pop   = out_ready && (fill_q != '0);
`ifdef AVST_SINK_ERR_CHECK_EN
    wr    = !rst && valid && legal && (guard_q == '0) && (!full || pop);
`else
    wr    = !rst && valid && (guard_q == '0) && (!full || pop);
`endif

    fill_d = fill_q;
    if (wr && !pop) begin
      fill_d = fill_q + FILL_ONE;
    end else if (!wr && pop) begin
      fill_d = fill_q - FILL_ONE;
    end

    // Grants already issued whose beats have not yet arrived
    grants = '0;
    if (READY_LATENCY > 0) begin
      grants = {3'b000, ready_q};
      for (int i = 0; i + 1 < int'(READY_LATENCY); i++) begin
        grants = grants + {3'b000, hist_q[i]};
      end
    end

    commit  = SUMW'(fill_d) + SUMW'(grants);
    ready_d = (commit < SUMW'(ENTRIES));

    hist_d    = hist_q;
    hist_d[0] = ready_q;
    for (int i = 1; i < int'(HISTW); i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      hist_q  <= '0;
      ready_q <= 1'b0;
      guard_q <= GUARD_INIT;
    end else begin
      if (wr) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      ready_q <= ready_d;
      // Beats landing before the first post-reset grant can mature are ignored
      if (guard_q != '0) begin
        guard_q <= guard_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr_q] <= data;
    end
  end

`ifdef AVST_SINK_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (valid && !legal && (guard_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_legal;
  assign unused_legal = legal;
  assign err          = 1'b0;
`endif

  assign ready     = ready_q;
  assign out_valid = (fill_q != '0);
  assign out_data  = mem[rptr_q];
  assign fill      = fill_q;

endmodule
